control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit_if.sv | 27 ++
 rtl/control_unit.sv | 120 ++++++++++++
 tb/tb_control_unit.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/control_unit_if.sv
// Bus between the control unit and its instruction memory, data memory and register file.
// The control unit uses the master modport. The environment around it uses the slave modport.
interface control_unit_if;
  logic [15:0] instr;
  logic [6:0]  pc_addr;
  logic [7:0]  d_addr;
  logic        d_wr;
  logic        rf_sel;
  logic [3:0]  rf_w_addr;
  logic [3:0]  rf_ra_addr;
  logic [3:0]  rf_rb_addr;
  logic        rf_w_en;
  logic [2:0]  alu_sel;
  logic [3:0]  state;

  modport master (
    input  instr,
    output pc_addr, d_addr, d_wr, rf_sel, rf_w_addr, rf_ra_addr, rf_rb_addr,
           rf_w_en, alu_sel, state
  );

  modport slave (
    output instr,
    input  pc_addr, d_addr, d_wr, rf_sel, rf_w_addr, rf_ra_addr, rf_rb_addr,
           rf_w_en, alu_sel, state
  );
endinterface

// File: rtl/control_unit.sv
// Multi-cycle control unit: fetch/decode/execute FSM with Moore outputs from state and IR.
// Define CU_ILLEGAL_TRAP_EN to halt on opcodes 0110-1111; otherwise they execute as NOOP.
module control_unit (
  input  logic           clk,
  input  logic           reset,
  control_unit_if.master bus
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_e;

  typedef enum logic [3:0] {
    OP_NOOP  = 4'b0000,
    OP_STORE = 4'b0001,
    OP_LOAD  = 4'b0010,
    OP_ADD   = 4'b0011,
    OP_SUB   = 4'b0100,
    OP_HALT  = 4'b0101
  } opcode_e;

`ifdef CU_ILLEGAL_TRAP_EN
  localparam state_e ILLEGAL_NEXT = S_HALT;
`else
  localparam state_e ILLEGAL_NEXT = S_NOOP;
`endif

  state_e      state_q, state_d;
  logic [6:0]  pc_q, pc_d;
  logic [15:0] ir_q, ir_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_INIT;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // NOTE: every signal gets a default first, so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    unique case (state_q)
      S_INIT:   state_d = S_FETCH;
      S_FETCH: begin
        ir_d    = bus.instr;
        pc_d    = pc_q + 7'd1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        unique case (ir_q[15:12])
          OP_NOOP:  state_d = S_NOOP;
          OP_STORE: state_d = S_STORE;
          OP_LOAD:  state_d = S_LOAD_A;
          OP_ADD:   state_d = S_ADD;
          OP_SUB:   state_d = S_SUB;
          OP_HALT:  state_d = S_HALT;
          default:  state_d = ILLEGAL_NEXT;
        endcase
      end
      S_LOAD_A: state_d = S_LOAD_B;
      S_NOOP, S_LOAD_B, S_STORE, S_ADD, S_SUB: state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_INIT;
    endcase
  end

  // These outputs depend only on the registered state and IR. The raw instruction never reaches them.
  always_comb begin
    bus.d_addr     = '0;
    bus.d_wr       = 1'b0;
    bus.rf_sel     = 1'b0;
    bus.rf_w_addr  = '0;
    bus.rf_ra_addr = '0;
    bus.rf_rb_addr = '0;
    bus.rf_w_en    = 1'b0;
    bus.alu_sel    = 3'b000;
    unique case (state_q)
      S_STORE: begin
        bus.d_addr     = ir_q[11:4];
        bus.rf_ra_addr = ir_q[3:0];
        bus.d_wr       = 1'b1;
      end
      S_LOAD_A, S_LOAD_B: begin
        bus.d_addr    = ir_q[11:4];
        bus.rf_sel    = 1'b1;
        bus.rf_w_addr = ir_q[3:0];
        bus.rf_w_en   = (state_q == S_LOAD_B);
      end
      S_ADD, S_SUB: begin
        bus.rf_ra_addr = ir_q[11:8];
        bus.rf_rb_addr = ir_q[7:4];
        bus.rf_w_addr  = ir_q[3:0];
        bus.rf_w_en    = 1'b1;
        bus.alu_sel    = (state_q == S_ADD) ? 3'b001 : 3'b010;
      end
      default: ;
    endcase
  end

  assign bus.pc_addr = pc_q;
  assign bus.state   = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit.
// An instruction-level model expands each fetched word into its expected per-cycle output trace.
module tb_control_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  control_unit_if cu_if ();
  logic [15:0] mem [128];

  control_unit dut (.clk(clk), .reset(reset), .bus(cu_if.master));

  always #5 clk = ~clk;
  assign cu_if.instr = mem[cu_if.pc_addr];

  int n_checks = 0;
  int n_pass   = 0;
  logic [36:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, expv, $time);
  endtask

  function automatic logic [36:0] mk(input logic [3:0] st, input logic [6:0] pc,
                                     input logic [7:0] da, input logic dw, input logic rs,
                                     input logic [3:0] wa, input logic [3:0] ra,
                                     input logic [3:0] rb, input logic we, input logic [2:0] alu);
    return {st, pc, da, dw, rs, wa, ra, rb, we, alu};
  endfunction

  function automatic logic [36:0] obs();
    return {cu_if.state, cu_if.pc_addr, cu_if.d_addr, cu_if.d_wr, cu_if.rf_sel,
            cu_if.rf_w_addr, cu_if.rf_ra_addr, cu_if.rf_rb_addr, cu_if.rf_w_en, cu_if.alu_sel};
  endfunction

  // Walks the program one instruction at a time and appends the cycles each instruction should produce.
  task automatic build_trace(input int ncycles);
    logic [6:0]  p;
    logic [15:0] ir;
    logic [3:0]  op;
    bit          halted;
    p = '0;
    halted = 0;
    exp_q.delete();
    while (exp_q.size() < ncycles) begin
      if (halted) begin
        exp_q.push_back(mk(9, p, 0, 0, 0, 0, 0, 0, 0, 0));
        continue;
      end
      ir = mem[p];
      op = ir[15:12];
      exp_q.push_back(mk(1, p, 0, 0, 0, 0, 0, 0, 0, 0));
      p = p + 7'd1;
      exp_q.push_back(mk(2, p, 0, 0, 0, 0, 0, 0, 0, 0));
      case (op)
        4'd0: exp_q.push_back(mk(3, p, 0, 0, 0, 0, 0, 0, 0, 0));
        4'd1: exp_q.push_back(mk(6, p, ir[11:4], 1, 0, 0, ir[3:0], 0, 0, 0));
        4'd2: begin
          exp_q.push_back(mk(4, p, ir[11:4], 0, 1, ir[3:0], 0, 0, 0, 0));
          exp_q.push_back(mk(5, p, ir[11:4], 0, 1, ir[3:0], 0, 0, 1, 0));
        end
        4'd3: exp_q.push_back(mk(7, p, 0, 0, 0, ir[3:0], ir[11:8], ir[7:4], 1, 3'b001));
        4'd4: exp_q.push_back(mk(8, p, 0, 0, 0, ir[3:0], ir[11:8], ir[7:4], 1, 3'b010));
        4'd5: halted = 1;
        default: begin
`ifdef CU_ILLEGAL_TRAP_EN
          halted = 1;
`else
          exp_q.push_back(mk(3, p, 0, 0, 0, 0, 0, 0, 0, 0));
`endif
        end
      endcase
    end
  endtask

  // Reset is released on a falling edge, so the next rising edge is the first INIT->FETCH edge.
  task automatic apply_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check({tag, "_reset"}, obs(), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_prog(input string tag, input int ncycles);
    build_trace(ncycles);
    apply_reset(tag);
    for (int c = 0; c < ncycles; c++) begin
      @(negedge clk);
      check($sformatf("%s_cyc%0d", tag, c), obs(), exp_q.pop_front());
    end
  endtask

  // Waits for the target state, then asserts reset between clock edges and checks that the write drops at once.
  task automatic reset_during(input string tag, input logic [3:0] target);
    bit found;
    found = 0;
    apply_reset(tag);
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (cu_if.state == target) found = 1;
    end
    check({tag, "_reached"}, 64'(found), 64'd1);
    check({tag, "_wr_before"}, 64'(cu_if.d_wr | cu_if.rf_w_en), 64'd1);
    #2 reset = 1'b1;
    #1;
    check({tag, "_async"}, obs(), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    check({tag, "_held"}, obs(), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [3:0] op;

    // Directed program covering every opcode, including an illegal one, then HALT for 30+ cycles.
    foreach (mem[i]) mem[i] = 16'h0000;
    mem[0] = 16'h0000; mem[1] = 16'h21B5; mem[2] = 16'h3123; mem[3] = 16'h4123;
    mem[4] = 16'h1FF7; mem[5] = 16'h7000; mem[6] = 16'h5000;
    run_prog("directed", 55);

    // 128 NOOPs: pc_addr must wrap from 127 back to 0.
    foreach (mem[i]) mem[i] = 16'h0000;
    run_prog("noop_wrap", 128 * 3 + 12);

    // Randomized programs with occasional HALT and illegal opcodes.
    for (int t = 0; t < 4; t++) begin
      foreach (mem[i]) begin
        r = $urandom_range(0, 39);
        if      (r < 6)  op = 4'd0;
        else if (r < 14) op = 4'd1;
        else if (r < 22) op = 4'd2;
        else if (r < 29) op = 4'd3;
        else if (r < 36) op = 4'd4;
        else if (r < 37) op = 4'd5;
        else             op = 4'($urandom_range(6, 15));
        mem[i] = {op, 12'($urandom)};
      end
      run_prog($sformatf("rand%0d", t), 300);
    end

    // Asynchronous reset in the middle of a LOAD write-back and in the middle of a STORE.
    foreach (mem[i]) mem[i] = 16'h0000;
    mem[0] = 16'h21B5;
    reset_during("rst_ldb", 4'd5);
    mem[0] = 16'h1FF7;
    reset_during("rst_store", 4'd6);

    // The design must run normally after reset is released again.
    mem[0] = 16'h3123;
    run_prog("after_rst", 10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
